// File: rtl/spi_cs_sequencer.sv
// SPI chip-select / byte sequencer.
// Sits between a host byte stream and a byte-level SPI engine. The block owns
// chip-select timing (setup, hold, inactive gaps) and feeds the engine one
// byte at a time. Each received byte is returned tagged with its index.
module spi_cs_sequencer #(
  parameter int NUM_CS           = 2,
  parameter int MAX_BYTES        = 8,
  parameter int CS_SETUP_CLKS    = 2,
  parameter int CS_HOLD_CLKS     = 2,
  parameter int CS_INACTIVE_CLKS = 2,
  localparam int CNT_W = $clog2(MAX_BYTES + 1),
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [SEL_W-1:0]  i_CS_Sel,
  input  logic [CNT_W-1:0]  i_Byte_Count,
  input  logic [7:0]        i_TX_Byte,
  input  logic              i_TX_Valid,
  output logic              o_TX_Ready,
  output logic [7:0]        o_RX_Byte,
  output logic              o_RX_DV,
  output logic [CNT_W-1:0]  o_RX_Index,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [7:0]        o_SPI_TX_Byte,
  output logic              o_SPI_TX_DV,
  input  logic              i_SPI_TX_Ready,
  input  logic              i_SPI_RX_DV,
  input  logic [7:0]        i_SPI_RX_Byte,
  output logic [NUM_CS-1:0] o_SPI_CS_n
);

  // One shared delay counter serves setup, hold and inactive phases.
  localparam int DLY_MAX_A = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int DLY_MAX   = (DLY_MAX_A > CS_INACTIVE_CLKS) ? DLY_MAX_A : CS_INACTIVE_CLKS;
  localparam int DLY_W     = $clog2(DLY_MAX + 1);

  localparam logic [DLY_W-1:0]  SETUP_LAST = DLY_W'(CS_SETUP_CLKS - 1);
  localparam logic [DLY_W-1:0]  HOLD_LAST  = DLY_W'(CS_HOLD_CLKS - 1);
  localparam logic [DLY_W-1:0]  INACT_LAST = DLY_W'(CS_INACTIVE_CLKS - 1);
  localparam logic [NUM_CS-1:0] CS_ALL_HI  = {NUM_CS{1'b1}};
  localparam logic [NUM_CS-1:0] CS_ONE     = NUM_CS'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_LOAD     = 3'd2,
    S_WAIT     = 3'd3,
    S_HOLD     = 3'd4,
    S_INACTIVE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              hold_arm_q, hold_arm_d;   // engine seen idle in HOLD
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_dv_q, rx_dv_d;
  logic [CNT_W-1:0]  rx_idx_q, rx_idx_d;
  logic              tx_ready_s;
  logic              start_ok_s;

  // Requests with zero/oversized length or a non-existent select are dropped.
  always_comb begin
    start_ok_s = (i_Byte_Count != {CNT_W{1'b0}}) &&
                 (i_Byte_Count <= CNT_W'(MAX_BYTES)) &&
                 (32'(i_CS_Sel) < 32'(NUM_CS));
  end

  // Next-state and output-register logic for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    hold_arm_d = hold_arm_q;
    count_d    = count_q;
    idx_d      = idx_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    rx_idx_d   = rx_idx_q;
    tx_ready_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_Start && start_ok_s) begin
          count_d = i_Byte_Count;
          idx_d   = {CNT_W{1'b0}};
          dly_d   = {DLY_W{1'b0}};
          cs_n_d  = ~(CS_ONE << i_CS_Sel);
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (dly_q == SETUP_LAST) begin
          dly_d   = {DLY_W{1'b0}};
          state_d = S_LOAD;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      S_LOAD: begin
        tx_ready_s = i_SPI_TX_Ready;
        if (i_TX_Valid && i_SPI_TX_Ready) begin
          tx_byte_d = i_TX_Byte;
          tx_dv_d   = 1'b1;
          state_d   = S_WAIT;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_WAIT: begin
        if (i_SPI_RX_DV) begin
          rx_byte_d = i_SPI_RX_Byte;
          rx_idx_d  = idx_q;
          rx_dv_d   = 1'b1;
          idx_d     = idx_q + CNT_W'(1);
          if (idx_q == (count_q - CNT_W'(1))) begin
            hold_arm_d = 1'b0;
            dly_d      = {DLY_W{1'b0}};
            state_d    = S_HOLD;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_HOLD: begin
        if (!hold_arm_q) begin
          if (i_SPI_TX_Ready) begin
            hold_arm_d = 1'b1;
          end else begin
            hold_arm_d = 1'b0;
          end
        end else if (dly_q == HOLD_LAST) begin
          cs_n_d     = CS_ALL_HI;
          done_d     = 1'b1;
          hold_arm_d = 1'b0;
          dly_d      = {DLY_W{1'b0}};
          state_d    = S_INACTIVE;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      S_INACTIVE: begin
        if (dly_q == INACT_LAST) begin
          busy_d  = 1'b0;
          dly_d   = {DLY_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      default: begin
        cs_n_d  = CS_ALL_HI;
        busy_d  = 1'b0;
        dly_d   = {DLY_W{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns every output to idle instantly.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= S_IDLE;
      dly_q      <= {DLY_W{1'b0}};
      hold_arm_q <= 1'b0;
      count_q    <= {CNT_W{1'b0}};
      idx_q      <= {CNT_W{1'b0}};
      cs_n_q     <= CS_ALL_HI;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_dv_q    <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      rx_idx_q   <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      hold_arm_q <= hold_arm_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      rx_idx_q   <= rx_idx_d;
    end
  end

  assign o_TX_Ready    = tx_ready_s;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Index    = rx_idx_q;
  assign o_Busy        = busy_q;
  assign o_Done        = done_q;
  assign o_SPI_TX_Byte = tx_byte_q;
  assign o_SPI_TX_DV   = tx_dv_q;
  assign o_SPI_CS_n    = cs_n_q;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Self-checking bench for spi_cs_sequencer: a loopback SPI engine model with
// random latency, a host byte source with optional stalls, and a monitor that
// logs DUT events so that each transaction can be compared against
// expectations derived from the block's timing rules.
module tb_spi_cs_sequencer;
  // Three select lines so that an out-of-range select is expressible.
  localparam int NUM_CS = 3;
  localparam int MAX_BYTES = 8;
  localparam int SETUP = 2;
  localparam int HOLD = 2;
  localparam int INACT = 2;
  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int SEL_W = $clog2(NUM_CS);
  localparam logic [NUM_CS-1:0] ALL1 = {NUM_CS{1'b1}};
  localparam logic [NUM_CS-1:0] ONE = NUM_CS'(1);

  logic clk, rst, start_m, extra_start, i_start;
  logic [SEL_W-1:0] cs_sel;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0] tx_byte, spi_rx_byte;
  logic tx_valid, spi_ready, spi_rx_dv;
  logic o_TX_Ready, o_RX_DV, o_Busy, o_Done, o_SPI_TX_DV;
  logic [7:0] o_RX_Byte, o_SPI_TX_Byte;
  logic [CNT_W-1:0] o_RX_Index;
  logic [NUM_CS-1:0] o_SPI_CS_n;

  assign i_start = start_m | extra_start;

  spi_cs_sequencer #(.NUM_CS(NUM_CS), .MAX_BYTES(MAX_BYTES), .CS_SETUP_CLKS(SETUP),
                     .CS_HOLD_CLKS(HOLD), .CS_INACTIVE_CLKS(INACT)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_start), .i_CS_Sel(cs_sel),
    .i_Byte_Count(byte_cnt), .i_TX_Byte(tx_byte), .i_TX_Valid(tx_valid),
    .o_TX_Ready(o_TX_Ready), .o_RX_Byte(o_RX_Byte), .o_RX_DV(o_RX_DV),
    .o_RX_Index(o_RX_Index), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_SPI_TX_Byte(o_SPI_TX_Byte), .o_SPI_TX_DV(o_SPI_TX_DV),
    .i_SPI_TX_Ready(spi_ready), .i_SPI_RX_DV(spi_rx_dv),
    .i_SPI_RX_Byte(spi_rx_byte), .o_SPI_CS_n(o_SPI_CS_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction description, written only by the main sequence.
  int txn_gen, txn_n, stall_idx, stall_len, poke_at;
  logic [7:0] txn_bytes [MAX_BYTES];
  logic [NUM_CS-1:0] exp_cs;

  // Logs and engine/host state, written only by the environment process.
  int cyc, gen_seen, rel, sent, stall_rem;
  logic [7:0] tx_log[$];
  logic [7:0] rx_b_log[$];
  int rx_i_log[$];
  int dv_cyc_log[$];
  int done_cnt, done_cyc, busy_rise_cyc, busy_fall_cyc, cs_low_cyc, cs_err, proto_err, rx_last_cyc;
  int eng_last_rx_cyc, eng_last_gap, eng_left, eng_gap, gap_cnt;
  logic eng_busy, prev_active, prev_busy, outstanding;
  logic [7:0] eng_byte;

  int checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment: DUT monitor, loopback engine and host byte source, all
  // updated on the falling edge so everything is stable for the next rise.
  initial begin
    cyc = 0; gen_seen = 0; rel = 0; sent = 0; stall_rem = 0;
    eng_busy = 1'b0; eng_left = 0; eng_gap = 0; gap_cnt = 0; eng_byte = 8'h00;
    eng_last_rx_cyc = 0; eng_last_gap = 0;
    prev_active = 1'b0; prev_busy = 1'b0; outstanding = 1'b0;
    done_cnt = 0; done_cyc = -1; busy_rise_cyc = -1; busy_fall_cyc = -1;
    cs_low_cyc = -1; cs_err = 0; proto_err = 0; rx_last_cyc = -1;
    spi_ready = 1'b1; spi_rx_dv = 1'b0; spi_rx_byte = 8'h00;
    tx_valid = 1'b0; tx_byte = 8'h00; extra_start = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (txn_gen != gen_seen) begin
        gen_seen = txn_gen; rel = 0; sent = 0; stall_rem = stall_len;
        tx_log.delete(); rx_b_log.delete(); rx_i_log.delete(); dv_cyc_log.delete();
        done_cnt = 0; done_cyc = -1; busy_rise_cyc = -1; busy_fall_cyc = -1;
        cs_low_cyc = -1; cs_err = 0; proto_err = 0; rx_last_cyc = -1;
      end else begin
        rel++;
      end
      extra_start = (poke_at >= 0) && (rel == poke_at);
      // monitor
      if (rst) begin
        prev_active = 1'b0; prev_busy = 1'b0; outstanding = 1'b0;
      end else begin
        if (o_SPI_TX_DV) begin
          if (outstanding) proto_err++;
          outstanding = 1'b1;
          tx_log.push_back(o_SPI_TX_Byte);
          dv_cyc_log.push_back(cyc);
          sent++;
        end
        if (o_RX_DV) begin
          rx_b_log.push_back(o_RX_Byte);
          rx_i_log.push_back(int'(o_RX_Index));
          rx_last_cyc = cyc;
        end
        if (o_Done) begin
          done_cnt++; done_cyc = cyc;
          if (o_SPI_CS_n != ALL1) cs_err++;
        end
        if ($countones(~o_SPI_CS_n) > 1) cs_err++;
        if (o_SPI_CS_n != ALL1 && o_SPI_CS_n != exp_cs) cs_err++;
        if (prev_active && o_SPI_CS_n == ALL1 && !o_Done) cs_err++;
        if (!prev_active && o_SPI_CS_n != ALL1 && cs_low_cyc < 0) cs_low_cyc = cyc;
        prev_active = (o_SPI_CS_n != ALL1);
        if (o_Busy && !prev_busy) busy_rise_cyc = cyc;
        if (!o_Busy && prev_busy) busy_fall_cyc = cyc;
        prev_busy = o_Busy;
      end
      // loopback engine: returns each byte after a random latency
      spi_rx_dv = 1'b0;
      if (eng_busy) begin
        if (eng_left == 1) begin
          spi_rx_dv = 1'b1; spi_rx_byte = eng_byte; eng_busy = 1'b0;
          eng_last_rx_cyc = cyc; eng_last_gap = eng_gap; outstanding = 1'b0;
          if (eng_gap == 0) spi_ready = 1'b1;
          else gap_cnt = eng_gap;
        end else begin
          eng_left--;
        end
      end else if (gap_cnt > 0) begin
        gap_cnt--;
        if (gap_cnt == 0) spi_ready = 1'b1;
      end
      if (!rst && o_SPI_TX_DV) begin
        eng_busy = 1'b1; eng_byte = o_SPI_TX_Byte; spi_ready = 1'b0;
        eng_left = int'($urandom_range(1, 4)); eng_gap = int'($urandom_range(0, 3));
      end
      // host byte source
      if (sent >= txn_n) begin
        tx_valid = 1'b0;
      end else if (sent == stall_idx && stall_rem > 0) begin
        tx_valid = 1'b0; stall_rem--;
      end else begin
        tx_valid = 1'b1; tx_byte = txn_bytes[sent];
      end
    end
  end

  // Announce a new transaction description; the environment picks it up on
  // the next falling edge.
  task automatic announce(input int sel, input int n, input int s_idx, input int s_len, input int poke);
    exp_cs = ~(ONE << sel);
    txn_n = n; stall_idx = s_idx; stall_len = s_len; poke_at = poke;
    txn_gen++;
    @(negedge clk); #1;
  endtask

  task automatic run_txn(input string tag, input int sel, input int n,
                         input int s_idx, input int s_len, input int poke);
    int st, g, waited;
    announce(sel, n, s_idx, s_len, poke);
    start_m = 1'b1; cs_sel = SEL_W'(sel); byte_cnt = CNT_W'(n); st = cyc;
    @(negedge clk); #1;
    start_m = 1'b0; cs_sel = SEL_W'((sel + 1) % NUM_CS); byte_cnt = CNT_W'(1);
    waited = 0;
    while (busy_fall_cyc < 0 && waited < 600) begin
      @(negedge clk); #1; waited++;
    end
    chk({tag, "_timeout"}, 32'(waited >= 600), 32'd0);
    repeat (6) begin @(negedge clk); #1; end
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_tx_count"}, 32'(tx_log.size()), 32'(n));
    chk({tag, "_rx_count"}, 32'(rx_b_log.size()), 32'(n));
    for (int i = 0; i < n && i < tx_log.size() && i < rx_b_log.size(); i++) begin
      chk($sformatf("%s_tx_byte%0d", tag, i), 32'(tx_log[i]), 32'(txn_bytes[i]));
      chk($sformatf("%s_rx_byte%0d", tag, i), 32'(rx_b_log[i]), 32'(txn_bytes[i]));
      chk($sformatf("%s_rx_idx%0d", tag, i), 32'(rx_i_log[i]), 32'(i));
    end
    chk({tag, "_cs_low_cycle"}, 32'(cs_low_cyc), 32'(st + 1));
    chk({tag, "_busy_rise_cycle"}, 32'(busy_rise_cyc), 32'(st + 1));
    if (dv_cyc_log.size() > 0)
      chk({tag, "_first_tx_dv_cycle"}, 32'(dv_cyc_log[0]), 32'(st + SETUP + 2));
    chk({tag, "_rx_dv_latency"}, 32'(rx_last_cyc), 32'(eng_last_rx_cyc + 1));
    g = (eng_last_gap > 1) ? eng_last_gap : 1;
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(eng_last_rx_cyc + g + HOLD + 1));
    chk({tag, "_busy_fall_cycle"}, 32'(busy_fall_cyc), 32'(done_cyc + INACT));
    chk({tag, "_cs_pattern"}, 32'(cs_err), 32'd0);
    chk({tag, "_tx_dv_per_rx"}, 32'(proto_err), 32'd0);
    if (s_idx > 0 && dv_cyc_log.size() > s_idx)
      chk({tag, "_stall_gap"}, 32'((dv_cyc_log[s_idx] - dv_cyc_log[s_idx - 1]) > s_len), 32'd1);
  endtask

  task automatic try_bad(input string tag, input int sel, input int n);
    exp_cs = ALL1; txn_n = 0; stall_idx = -1; stall_len = 0; poke_at = -1;
    txn_gen++;
    @(negedge clk); #1;
    start_m = 1'b1; cs_sel = SEL_W'(sel); byte_cnt = CNT_W'(n);
    @(negedge clk); #1;
    start_m = 1'b0;
    repeat (8) begin @(negedge clk); #1; end
    chk({tag, "_cs_idle"}, 32'(cs_low_cyc), 32'hFFFF_FFFF);
    chk({tag, "_busy_idle"}, 32'(busy_rise_cyc), 32'hFFFF_FFFF);
    chk({tag, "_no_done"}, 32'(done_cnt), 32'd0);
  endtask

  initial begin
    int n, sel, s_idx, s_len, waited;
    checks = 0; errors = 0;
    rst = 1'b1; start_m = 1'b0; cs_sel = '0; byte_cnt = '0;
    txn_gen = 0; txn_n = 0; stall_idx = -1; stall_len = 0; poke_at = -1; exp_cs = ALL1;
    for (int i = 0; i < MAX_BYTES; i++) txn_bytes[i] = 8'h00;
    repeat (3) begin @(negedge clk); #1; end
    chk("rst_cs_n", 32'(o_SPI_CS_n), 32'(ALL1));
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_done", 32'(o_Done), 32'd0);
    chk("rst_spi_tx_dv", 32'(o_SPI_TX_DV), 32'd0);
    chk("rst_spi_tx_byte", 32'(o_SPI_TX_Byte), 32'd0);
    chk("rst_rx_dv", 32'(o_RX_DV), 32'd0);
    chk("rst_rx_byte", 32'(o_RX_Byte), 32'd0);
    chk("rst_rx_index", 32'(o_RX_Index), 32'd0);
    chk("rst_tx_ready", 32'(o_TX_Ready), 32'd0);
    rst = 1'b0;
    repeat (2) begin @(negedge clk); #1; end

    // Single byte on CS 0.
    txn_bytes[0] = 8'hA5;
    run_txn("one_byte", 0, 1, -1, 0, -1);

    // Three bytes on CS 1, with a second start request while busy.
    txn_bytes[0] = 8'h01; txn_bytes[1] = 8'h02; txn_bytes[2] = 8'h03;
    run_txn("three_byte", 1, 3, -1, 0, 5);

    // Same, host stalls 20 cycles before the second byte.
    run_txn("host_stall", 1, 3, 1, 20, -1);

    // Requests that must be ignored.
    try_bad("count_zero", 0, 0);
    try_bad("count_over", 1, MAX_BYTES + 1);
    try_bad("sel_range", NUM_CS, 2);

    // Asynchronous reset while the second of three bytes is in flight.
    txn_bytes[0] = 8'h5A; txn_bytes[1] = 8'hC3; txn_bytes[2] = 8'h3C;
    announce(2, 3, -1, 0, -1);
    start_m = 1'b1; cs_sel = SEL_W'(2); byte_cnt = CNT_W'(3);
    @(negedge clk); #1;
    start_m = 1'b0;
    waited = 0;
    while (tx_log.size() < 2 && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    chk("rst_mid_reach_byte2", 32'(tx_log.size()), 32'd2);
    #2; rst = 1'b1; #1;
    chk("rst_mid_cs_n", 32'(o_SPI_CS_n), 32'(ALL1));
    chk("rst_mid_busy", 32'(o_Busy), 32'd0);
    chk("rst_mid_spi_tx_byte", 32'(o_SPI_TX_Byte), 32'd0);
    chk("rst_mid_rx_index", 32'(o_RX_Index), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (10) begin @(negedge clk); #1; end
    chk("rst_mid_no_late_rx", 32'(rx_b_log.size()), 32'd1);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    txn_bytes[0] = 8'h96;
    run_txn("after_reset", 0, 1, -1, 0, -1);

    // Randomized transactions.
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, MAX_BYTES));
      sel = int'($urandom_range(0, NUM_CS - 1));
      for (int i = 0; i < MAX_BYTES; i++) txn_bytes[i] = 8'($urandom_range(0, 255));
      s_idx = -1; s_len = 0;
      if (n > 1 && $urandom_range(0, 1) == 1) begin
        s_idx = int'($urandom_range(1, n - 1));
        s_len = int'($urandom_range(1, 6));
      end
      run_txn($sformatf("rand%0d", t), sel, n, s_idx, s_len,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
